// File: rtl/dlsc_axi_router_channel_source_pkt_if.sv
// rtl/dlsc_axi_router_channel_source_pkt_if.sv - command, source, arbiter and lane signals of one channel source endpoint
interface dlsc_axi_router_channel_source_pkt_if #(
    parameter int DATA   = 32,
    parameter int SINKS  = 1,
    parameter int SINKSB = 1,
    parameter int LANES  = 1,
    parameter int LANESB = 1,
    parameter int LVLB   = 5
);
    logic              cmd_full;
    logic              cmd_push;
    logic [SINKSB-1:0] cmd_sink;
    logic              source_ready;
    logic              source_valid;
    logic              source_last;
    logic [DATA-1:0]   source_data;
    logic [SINKS-1:0]  sink_source;
    logic              arb_req;
    logic [SINKSB-1:0] arb_req_sink;
    logic              arb_grant;
    logic [LANESB-1:0] arb_grant_lane;
    logic [LANES-1:0]  lane_in_ready;
    logic              lane_in_valid;
    logic              lane_in_last;
    logic [DATA-1:0]   lane_in_data;
    logic [LVLB-1:0]   buf_level;
    logic              err_overflow;

    modport slave (
        input  cmd_push, cmd_sink, source_valid, source_last, source_data, sink_source,
               arb_grant, arb_grant_lane, lane_in_ready,
        output cmd_full, source_ready, arb_req, arb_req_sink, lane_in_valid, lane_in_last,
               lane_in_data, buf_level, err_overflow
    );

    modport master (
        output cmd_push, cmd_sink, source_valid, source_last, source_data, sink_source,
               arb_grant, arb_grant_lane, lane_in_ready,
        input  cmd_full, source_ready, arb_req, arb_req_sink, lane_in_valid, lane_in_last,
               lane_in_data, buf_level, err_overflow
    );
endinterface

// File: rtl/dlsc_axi_router_channel_source_pkt.sv
// rtl/dlsc_axi_router_channel_source_pkt.sv - per-source channel endpoint: command queue, beat buffer, lane request and grant tracking
module dlsc_axi_router_channel_source_pkt #(
    parameter int DATA     = 32,
    parameter int MOT      = 16,
    parameter int SINKS    = 1,
    parameter int SINKSB   = 1,
    parameter int LANES    = 1,
    parameter int LANESB   = 1,
    parameter int BUFDEPTH = 16,
    parameter int MODE     = 0,
    parameter int THRESH   = 4,
    parameter int LVLB     = 5
) (
    input  logic clk,
    input  logic rst,
    dlsc_axi_router_channel_source_pkt_if.slave ch
);
    localparam int CAW  = (MOT > 1) ? $clog2(MOT) : 1;
    localparam int BAW  = (BUFDEPTH > 1) ? $clog2(BUFDEPTH) : 1;
    localparam int PKTW = BAW + 1;

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t            state_q;
    logic [LANESB-1:0] lane_q;
    logic              err_q;

    logic              grant;
    logic              lane_rdy;
    logic              sink_ok;
    logic              cmd_empty;
    logic [SINKSB-1:0] head_sink;
    logic              pop;
    logic              out_last;
    logic              grant_clear;
    logic              grant_take;
    logic              eligible;

    assign grant       = (state_q == ST_ACTIVE);
    assign lane_rdy    = |(ch.lane_in_ready & (LANES'(1) << lane_q));
    assign sink_ok     = |(ch.sink_source & (SINKS'(1) << head_sink));
    assign grant_clear = pop && out_last;
    // A grant is only taken when idle or on the cycle the current burst finishes.
    assign grant_take  = ch.arb_grant && (!grant || grant_clear);

    assign ch.arb_req      = eligible && (!grant || grant_clear) && !cmd_empty && sink_ok;
    assign ch.arb_req_sink = head_sink;
    assign ch.err_overflow = err_q;

    generate
        if (SINKS > 1) begin : g_cmd
            logic [SINKSB-1:0] mem [MOT];
            logic [CAW-1:0]    wr_q;
            logic [CAW-1:0]    rd_q;
            logic [CAW:0]      cnt_q;
            logic              push;
            logic              cpop;

            assign push = ch.cmd_push && (cnt_q != (CAW+1)'(MOT));
            assign cpop = grant_take && (cnt_q != '0);

            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_q] <= ch.cmd_sink;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_q  <= '0;
                    rd_q  <= '0;
                    cnt_q <= '0;
                end else begin
                    if (push) begin
                        wr_q <= wr_q + 1'b1;
                    end
                    if (cpop) begin
                        rd_q <= rd_q + 1'b1;
                    end
                    cnt_q <= cnt_q + {{CAW{1'b0}}, push} - {{CAW{1'b0}}, cpop};
                end
            end

            assign head_sink   = mem[rd_q];
            assign cmd_empty   = (cnt_q == '0);
            // One entry held back because the upstream push is pipelined by a cycle.
            assign ch.cmd_full = (cnt_q >= (CAW+1)'(MOT-1));
        end else begin : g_nocmd
            logic unused_cmd;
            assign unused_cmd  = ^{ch.cmd_push, ch.cmd_sink};
            assign head_sink   = '0;
            assign cmd_empty   = 1'b0;
            assign ch.cmd_full = 1'b0;
        end

        if (BUFDEPTH > 0) begin : g_buf
            logic [DATA:0]     mem [BUFDEPTH];
            logic [BAW-1:0]    wr_q;
            logic [BAW-1:0]    rd_q;
            logic [PKTW-1:0]   lvl_q;
            logic [PKTW-1:0]   pkt_q;
            logic [PKTW-1:0]   lvl_n;
            logic [PKTW-1:0]   pkt_n;
            logic              rdy_q;
            logic              full;
            logic              valid;
            logic              wr;

            assign full            = (lvl_q == PKTW'(BUFDEPTH));
            assign valid           = (lvl_q != '0);
            assign ch.source_ready = rdy_q && !full;
            assign wr              = ch.source_valid && ch.source_ready;
            assign out_last        = mem[rd_q][DATA];
            assign pop             = grant && lane_rdy && valid;
            assign ch.lane_in_valid = grant && valid;
            assign ch.lane_in_last = out_last;
            assign ch.lane_in_data = mem[rd_q][DATA-1:0];
            assign ch.buf_level    = LVLB'(lvl_q);

            // Judge availability after this cycle's pop so the next burst can be
            // requested during the last beat of the current one.
            assign lvl_n = lvl_q - PKTW'(pop);
            assign pkt_n = pkt_q - PKTW'(grant_clear);

            always_comb begin
                case (MODE)
                    1:       eligible = (pkt_n != '0) || full;
                    2:       eligible = (pkt_n != '0) || (lvl_n >= PKTW'(THRESH));
                    default: eligible = (lvl_n != '0);
                endcase
            end

            always_ff @(posedge clk) begin
                if (wr) begin
                    mem[wr_q] <= {ch.source_last, ch.source_data};
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdy_q <= 1'b0;
                    wr_q  <= '0;
                    rd_q  <= '0;
                    lvl_q <= '0;
                    pkt_q <= '0;
                end else begin
                    rdy_q <= 1'b1;
                    if (wr) begin
                        wr_q <= wr_q + 1'b1;
                    end
                    if (pop) begin
                        rd_q <= rd_q + 1'b1;
                    end
                    lvl_q <= lvl_q + PKTW'(wr) - PKTW'(pop);
                    pkt_q <= pkt_q + PKTW'(wr && ch.source_last) - PKTW'(grant_clear);
                end
            end
        end else begin : g_pass
            assign ch.source_ready  = grant && lane_rdy;
            assign pop              = ch.source_valid && ch.source_ready;
            assign out_last         = ch.source_last;
            assign ch.lane_in_valid = grant && ch.source_valid;
            assign ch.lane_in_last  = ch.source_last;
            assign ch.lane_in_data  = ch.source_data;
            assign ch.buf_level     = '0;
            assign eligible         = ch.source_valid && !grant;
        end
    endgenerate

    // A grant arriving while a burst is still in flight is dropped and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lane_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (grant_take) begin
                state_q <= ST_ACTIVE;
                lane_q  <= ch.arb_grant_lane;
            end else if (grant_clear) begin
                state_q <= ST_IDLE;
            end else if (ch.arb_grant) begin
                err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dlsc_axi_router_channel_source_pkt.sv
// tb/tb_dlsc_axi_router_channel_source_pkt.sv - scoreboard bench for the packet-mode channel source
module tb_dlsc_axi_router_channel_source_pkt;
    logic clk;
    logic rst0;
    logic rst12;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_lane = 0;
    logic [32:0] sb [$];

    dlsc_axi_router_channel_source_pkt_if #(.DATA(32), .SINKS(4), .SINKSB(2), .LANES(2), .LANESB(1), .LVLB(5)) if0 ();
    dlsc_axi_router_channel_source_pkt_if #(.DATA(32), .SINKS(4), .SINKSB(2), .LANES(2), .LANESB(1), .LVLB(5)) if1 ();
    dlsc_axi_router_channel_source_pkt_if #(.DATA(32), .SINKS(4), .SINKSB(2), .LANES(2), .LANESB(1), .LVLB(5)) if2 ();

    dlsc_axi_router_channel_source_pkt #(.DATA(32), .MOT(4), .SINKS(4), .SINKSB(2), .LANES(2), .LANESB(1),
        .BUFDEPTH(16), .MODE(0), .THRESH(4), .LVLB(5)) u0 (.clk(clk), .rst(rst0), .ch(if0));
    dlsc_axi_router_channel_source_pkt #(.DATA(32), .MOT(4), .SINKS(4), .SINKSB(2), .LANES(2), .LANESB(1),
        .BUFDEPTH(16), .MODE(1), .THRESH(4), .LVLB(5)) u1 (.clk(clk), .rst(rst12), .ch(if1));
    dlsc_axi_router_channel_source_pkt #(.DATA(32), .MOT(4), .SINKS(4), .SINKSB(2), .LANES(2), .LANESB(1),
        .BUFDEPTH(16), .MODE(2), .THRESH(4), .LVLB(5)) u2 (.clk(clk), .rst(rst12), .ch(if2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [1:0] s);
        if0.cmd_push = 1'b1;
        if0.cmd_sink = s;
        tick();
        if0.cmd_push = 1'b0;
    endtask

    task automatic send0(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            if0.source_valid = 1'b1;
            if0.source_data  = $urandom;
            if0.source_last  = with_last && (i == n - 1);
            sb.push_back({if0.source_last, if0.source_data});
            tick();
        end
        if0.source_valid = 1'b0;
        if0.source_last  = 1'b0;
    endtask

    task automatic push12();
        if1.cmd_push = 1'b1;
        if2.cmd_push = 1'b1;
        tick();
        if1.cmd_push = 1'b0;
        if2.cmd_push = 1'b0;
    endtask

    task automatic send12(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            if1.source_valid = 1'b1;
            if2.source_valid = 1'b1;
            if1.source_data  = $urandom;
            if2.source_data  = if1.source_data;
            if1.source_last  = with_last && (i == n - 1);
            if2.source_last  = if1.source_last;
            tick();
        end
        if1.source_valid = 1'b0;
        if2.source_valid = 1'b0;
        if1.source_last  = 1'b0;
        if2.source_last  = 1'b0;
    endtask

    task automatic reset12();
        rst12 = 1'b1;
        tick();
        rst12 = 1'b0;
        tick();
    endtask

    // Beats accepted by the expected lane are matched in order against the scoreboard.
    always @(negedge clk) begin
        if (!rst0 && if0.lane_in_valid && if0.lane_in_ready[exp_lane]) begin
            check("sb_avail", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                check("beat", {if0.lane_in_last, if0.lane_in_data}, sb.pop_front());
            end
        end
    end

    initial begin
        rst0 = 1'b1;
        rst12 = 1'b1;
        if0.cmd_push = 0; if0.cmd_sink = 0; if0.source_valid = 0; if0.source_last = 0;
        if0.source_data = 0; if0.sink_source = 4'hF; if0.arb_grant = 0; if0.arb_grant_lane = 0;
        if0.lane_in_ready = 2'b00;
        if1.cmd_push = 0; if1.cmd_sink = 0; if1.source_valid = 0; if1.source_last = 0;
        if1.source_data = 0; if1.sink_source = 4'hF; if1.arb_grant = 0; if1.arb_grant_lane = 0;
        if1.lane_in_ready = 2'b00;
        if2.cmd_push = 0; if2.cmd_sink = 0; if2.source_valid = 0; if2.source_last = 0;
        if2.source_data = 0; if2.sink_source = 4'hF; if2.arb_grant = 0; if2.arb_grant_lane = 0;
        if2.lane_in_ready = 2'b00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arb_req", if0.arb_req, 0);
        check("rst_lane_valid", if0.lane_in_valid, 0);
        check("rst_buf_level", if0.buf_level, 0);
        check("rst_cmd_full", if0.cmd_full, 0);
        check("rst_source_ready", if0.source_ready, 0);
        check("rst_err", if0.err_overflow, 0);
        tick();
        rst0 = 1'b0;
        rst12 = 1'b0;
        tick();
        @(negedge clk);
        check("post_rst_source_ready", if0.source_ready, 1);

        // Two 4-beat bursts to sinks 2 and 1, then a third command for later
        push0(2'd2);
        push0(2'd1);
        push0(2'd3);
        @(negedge clk);
        check("cmd_full_at_mot_m1", if0.cmd_full, 1);
        send0(4, 1);
        send0(4, 1);
        @(negedge clk);
        check("level_two_bursts", if0.buf_level, 8);
        check("req_two_bursts", if0.arb_req, 1);
        check("req_sink_first", if0.arb_req_sink, 2);

        if0.lane_in_ready = 2'b10;
        exp_lane = 1;
        if0.arb_grant = 1'b1;
        if0.arb_grant_lane = 1'b1;
        tick();
        if0.arb_grant = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 4) begin
                if0.arb_grant = 1'b1;
                if0.arb_grant_lane = 1'b0;
            end
            if (c == 5) begin
                if0.arb_grant = 1'b0;
                if0.lane_in_ready = 2'b01;
                exp_lane = 0;
            end
            @(negedge clk);
            check($sformatf("no_bubble_c%0d", c), if0.lane_in_valid, 1);
            if (c == 1) check("cmd_full_after_pop", if0.cmd_full, 0);
            if (c == 4) begin
                check("req_on_last_beat", if0.arb_req, 1);
                check("req_sink_second", if0.arb_req_sink, 1);
            end
            tick();
        end
        @(negedge clk);
        check("idle_after_bursts", if0.lane_in_valid, 0);
        check("level_drained", if0.buf_level, 0);
        check("sb_drained_1", sb.size(), 0);
        check("no_err_yet", if0.err_overflow, 0);

        // Overlapping grant mid-burst and sink gating
        if0.lane_in_ready = 2'b10;
        exp_lane = 1;
        send0(4, 1);
        @(negedge clk);
        if0.sink_source = 4'b0111;
        #1;
        check("req_sink_blocked", if0.arb_req, 0);
        if0.sink_source = 4'hF;
        #1;
        check("req_sink_open", if0.arb_req, 1);
        check("req_sink_third", if0.arb_req_sink, 3);
        if0.arb_grant = 1'b1;
        if0.arb_grant_lane = 1'b1;
        tick();
        if0.arb_grant = 1'b0;
        tick();
        if0.arb_grant = 1'b1;
        if0.arb_grant_lane = 1'b0;
        tick();
        if0.arb_grant = 1'b0;
        @(negedge clk);
        check("err_overflow_set", if0.err_overflow, 1);
        tick();
        tick();
        @(negedge clk);
        check("idle_after_err_burst", if0.lane_in_valid, 0);
        check("err_sticky", if0.err_overflow, 1);
        check("sb_drained_2", sb.size(), 0);

        // Asynchronous reset in the middle of a burst
        push0(2'd0);
        send0(4, 1);
        if0.lane_in_ready = 2'b01;
        exp_lane = 0;
        if0.arb_grant = 1'b1;
        if0.arb_grant_lane = 1'b0;
        tick();
        if0.arb_grant = 1'b0;
        #3;
        rst0 = 1'b1;
        #1;
        check("mid_rst_lane_valid", if0.lane_in_valid, 0);
        check("mid_rst_level", if0.buf_level, 0);
        check("mid_rst_err", if0.err_overflow, 0);
        check("mid_rst_cmd_full", if0.cmd_full, 0);
        check("mid_rst_arb_req", if0.arb_req, 0);
        sb.delete();
        tick();
        rst0 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            check("post_rst_no_valid", if0.lane_in_valid, 0);
        end

        // Packet mode (u1) and threshold mode (u2) request eligibility
        push12();
        send12(3, 0);
        @(negedge clk);
        check("m1_three_beats", if1.arb_req, 0);
        check("m2_three_beats", if2.arb_req, 0);
        send12(1, 1);
        @(negedge clk);
        check("m1_full_burst", if1.arb_req, 1);
        check("m2_fourth_beat", if2.arb_req, 1);

        reset12();
        push12();
        send12(2, 1);
        @(negedge clk);
        check("m1_short_burst", if1.arb_req, 1);
        check("m2_short_burst", if2.arb_req, 1);

        reset12();
        push12();
        send12(4, 0);
        @(negedge clk);
        check("m1_four_no_last", if1.arb_req, 0);
        check("m2_thresh_no_last", if2.arb_req, 1);
        send12(11, 0);
        @(negedge clk);
        check("m1_fifteen", if1.arb_req, 0);
        check("m1_ready_not_full", if1.source_ready, 1);
        send12(1, 0);
        @(negedge clk);
        check("m1_full_req", if1.arb_req, 1);
        check("m1_full_level", if1.buf_level, 16);
        check("m1_full_ready", if1.source_ready, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dlsc_axi_router_channel_source_pkt.md
# dlsc_axi_router_channel_source_pkt

Source-side channel endpoint for the AXI router: queues per-burst destination commands, buffers one source's beat stream, arbitrates for a crossbar lane, and streams each burst into its granted lane. It is a parametrised successor to the cut-through source with three additions: a configurable data buffer depth, a request mode that withholds arbitration until a complete burst (or a threshold of beats) is buffered, and output gating with status and error reporting. One instance sits per source port per channel (AW/W/AR/R/B) between the port adapter and the lane arbiter.

## Interface
- DATA, 32, payload width
- MOT, 16, command FIFO depth (max outstanding bursts); power of 2, ≥2
- SINKS / SINKSB, 1 / 1, sink count / index width
- LANES / LANESB, 1 / 1, lane count / index width
- BUFDEPTH, 16, data buffer depth; 0 = no buffer, else power of 2, ≥4
- MODE, 0, request mode: 0 cut-through, 1 packet (full burst), 2 threshold; must be 0 when BUFDEPTH=0
- THRESH, 4, beat threshold for MODE 2; 1..BUFDEPTH
- LVLB, 5, width of buf_level (≥ log2(BUFDEPTH)+1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_full  out  1  command FIFO almost full (one entry reserved)
- cmd_push  in  1  push destination for one burst
- cmd_sink  in  SINKSB  destination sink
- source_ready / source_valid / source_last  out/in/in  1  source handshake
- source_data  in  DATA  source payload
- sink_source  in  SINKS  per sink: sink currently accepts traffic from this source
- arb_req  out  1  lane request
- arb_req_sink  out  SINKSB  requested sink (head of command FIFO)
- arb_grant  in  1  grant strobe, one cycle
- arb_grant_lane  in  LANESB  granted lane
- lane_in_ready  in  LANES  per-lane ready
- lane_in_valid / lane_in_last  out  1  beat valid / last, toward lanes
- lane_in_data  out  DATA  beat payload
- buf_level  out  LVLB  beats in buffer (0 when BUFDEPTH=0)
- err_overflow  out  1  sticky: grant while already granted

## Operation
- Command FIFO (SINKS>1): push on cmd_push; pop on accepted arb_grant; cmd_full at MOT-1 entries (push has 1-cycle pipeline upstream). SINKS=1: cmd_full=0, arb_req_sink=0, never empty.
- Buffer: source_ready = !full; write on source_valid&&source_ready. BUFDEPTH=0: pass-through, source_ready = grant && lane_in_ready[lane].
- pkt_count: +1 on write with last, −1 on pop with last, unchanged if both; width log2(BUFDEPTH)+1, never wraps.
- Pop (grant_clear when last): pop = grant && lane_in_ready[lane] && buffer valid. lane_in_valid = grant && buffer valid (gated, unlike prior generation).
- Availability after this cycle's pop: lvl_n = level − pop, pkt_n = pkt_count − (pop&&last).
- Eligible: MODE0 lvl_n≥1; MODE1 pkt_n≥1 or buffer full; MODE2 pkt_n≥1 or lvl_n≥THRESH. BUFDEPTH=0: source_valid && !grant.
- arb_req = eligible && (!grant || grant_clear) && cmd not empty && sink_source[arb_req_sink].
- Grant FSM, states IDLE (grant=0) / ACTIVE (grant=1): IDLE→ACTIVE on arb_grant (latch lane); ACTIVE→IDLE on grant_clear; grant_clear and arb_grant same cycle → stay ACTIVE, new lane.
- arb_grant in ACTIVE without grant_clear: ignored (no lane change, no pop), err_overflow set until reset.

## Timing
- Reset (async assert, sync release): grant=0, lane=0, FIFOs empty, pkt_count=0, err_overflow=0; outputs arb_req=0, lane_in_valid=0, buf_level=0, cmd_full=0, source_ready=0 during reset, 1 first cycle after (BUFDEPTH>0).
- Source write → visible at buffer output next cycle (1-cycle latency); buf_level registered.
- arb_grant cycle N → first beat may transfer at N+1.
- Back-to-back bursts (BUFDEPTH>0): request during last-beat cycle; grant then gives zero idle cycles between bursts. BUFDEPTH=0: minimum one idle cycle.
- Reset mid-burst: all state discarded, buffered beats lost; no lane_in_valid until regranted.

## Test plan
- MODE0, BUFDEPTH=16, SINKS=4: push sink 2, send 4-beat burst, grant lane 1 at cycle N -> arb_req_sink=2, beats on lane 1 at N+1..N+4, grant drops after last.
- MODE1: feed 3 beats without last -> arb_req stays 0; 4th beat with last -> arb_req=1 next cycle; 16 beats no last -> arb_req at full.
- MODE2, THRESH=4: 3 beats -> no req; 4th -> req; 2-beat complete burst -> req.
- Two queued 4-beat bursts, grants on last-beat cycle -> 8 consecutive beats, lanes switched 1→0 with no bubble; pkt_count 2→0.
- Grant while ACTIVE mid-burst -> err_overflow=1 sticky, lane unchanged; sink_source[sink]=0 -> arb_req=0.
- Async rst pulse mid-burst -> grant, buf_level, err_overflow, lane_in_valid all 0 immediately; cmd_full=0.
